// File: rtl/edf_queue_scheduler.sv
// Earliest-deadline-first arbiter over NUMBER_OF_QUEUES core queues: picks the most urgent
// non-empty queue, waits out the buffer read latency, then offers the head packet downstream.

module edf_deadline_cnt #(
  parameter int REGISTER_SIZE = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [REGISTER_SIZE-1:0] period,
  input  logic                     empty,
  input  logic                     pop,
  output logic [REGISTER_SIZE-1:0] cnt,
  output logic                     miss
);
  logic [REGISTER_SIZE-1:0] cnt_q, cnt_d;
  logic                     miss_q, miss_d;

  // Held at the period while empty so the deadline starts at packet arrival.
  always_comb begin
    cnt_d = cnt_q;
    if (empty || pop)        cnt_d = period;
    else if (cnt_q != '0)    cnt_d = cnt_q - REGISTER_SIZE'(1);
    miss_d = ~empty & (cnt_q == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= period;
      miss_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      miss_q <= miss_d;
    end
  end

  assign cnt  = cnt_q;
  assign miss = miss_q;
endmodule

module edf_queue_scheduler #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int REGISTER_SIZE    = 32,
  parameter int DATA_SIZE        = 678,
  parameter int READ_LATENCY     = 1
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic                                             enable,
  input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]   queues_period,
  input  logic [NUMBER_OF_QUEUES-1:0]                      empty,
  input  logic [DATA_SIZE-1:0]                             queues_to_buffer_packet,
  output logic [$clog2(NUMBER_OF_QUEUES)-1:0]              core_id,
  output logic                                             scheduler_to_queues_ready,
  output logic [DATA_SIZE-1:0]                             out_packet,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [NUMBER_OF_QUEUES-1:0]                      deadline_miss
);
  localparam int ID_W  = $clog2(NUMBER_OF_QUEUES);
  localparam int LAT_W = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, OFFER} state_t;

  state_t                 state_q, state_d;
  logic [ID_W-1:0]        core_id_q, core_id_d;
  logic [LAT_W-1:0]       lat_q, lat_d;
  logic [DATA_SIZE-1:0]   out_packet_q, out_packet_d;
  logic                   out_valid_q, out_valid_d;

  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] cnt;
  logic [NUMBER_OF_QUEUES-1:0]                    pop_vec;
  logic                                           pop;
  logic                                           win_valid;
  logic [ID_W-1:0]                                win_idx;
  logic [REGISTER_SIZE-1:0]                       win_cnt;

  for (genvar g = 0; g < NUMBER_OF_QUEUES; g++) begin : g_lane
    edf_deadline_cnt #(.REGISTER_SIZE(REGISTER_SIZE)) u_cnt (
      .clock  (clock),
      .reset  (reset),
      .period (queues_period[g]),
      .empty  (empty[g]),
      .pop    (pop_vec[g]),
      .cnt    (cnt[g]),
      .miss   (deadline_miss[g])
    );
  end

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    win_cnt   = '0;
    for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
      if (!empty[i] && (!win_valid || cnt[i] < win_cnt)) begin
        win_valid = 1'b1;
        win_idx   = ID_W'(i);
        win_cnt   = cnt[i];
      end
    end
  end

  // Masked by reset so an in-flight offer is abandoned without popping.
  assign pop = out_valid_q & out_ready & ~reset;

  always_comb begin
    pop_vec            = '0;
    pop_vec[core_id_q] = pop;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      core_id_q    <= '0;
      lat_q        <= '0;
      out_packet_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_id_q    <= core_id_d;
      lat_q        <= lat_d;
      out_packet_q <= out_packet_d;
      out_valid_q  <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable && win_valid) state_d = WAIT;
      WAIT:    if (lat_q <= LAT_W'(1)) state_d = OFFER;
      OFFER:   if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    core_id_d    = core_id_q;
    lat_d        = lat_q;
    out_packet_d = out_packet_q;
    out_valid_d  = out_valid_q;
    case (state_q)
      IDLE: begin
        if (enable && win_valid) begin
          core_id_d = win_idx;
          lat_d     = LAT_W'(READ_LATENCY);
        end
      end
      WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q <= LAT_W'(1)) begin
          out_packet_d = queues_to_buffer_packet;
          out_valid_d  = 1'b1;
        end
      end
      OFFER:   if (out_ready) out_valid_d = 1'b0;
      default: out_valid_d = 1'b0;
    endcase
  end

  assign core_id                   = core_id_q;
  assign out_packet                = out_packet_q;
  assign out_valid                 = out_valid_q;
  assign scheduler_to_queues_ready = pop;
endmodule

// File: tb/tb_edf_queue_scheduler.sv
// Directed bench for edf_queue_scheduler: behavioural queues plus a combinational head buffer.
module tb_edf_queue_scheduler;
  localparam int NQ = 4;
  localparam int RS = 32;
  localparam int DS = 678;
  localparam int RL = 1;
  localparam int IW = 2;

  logic                   clock = 1'b0;
  logic                   reset, enable, out_ready;
  logic [NQ-1:0][RS-1:0]  queues_period;
  logic [NQ-1:0]          empty;
  logic [DS-1:0]          queues_to_buffer_packet, out_packet;
  logic [IW-1:0]          core_id;
  logic                   scheduler_to_queues_ready, out_valid;
  logic [NQ-1:0]          deadline_miss;

  edf_queue_scheduler #(
    .NUMBER_OF_QUEUES(NQ), .REGISTER_SIZE(RS), .DATA_SIZE(DS), .READ_LATENCY(RL)
  ) dut (
    .clock                     (clock),
    .reset                     (reset),
    .enable                    (enable),
    .queues_period             (queues_period),
    .empty                     (empty),
    .queues_to_buffer_packet   (queues_to_buffer_packet),
    .core_id                   (core_id),
    .scheduler_to_queues_ready (scheduler_to_queues_ready),
    .out_packet                (out_packet),
    .out_valid                 (out_valid),
    .out_ready                 (out_ready),
    .deadline_miss             (deadline_miss)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NQ-1:0][RS-1:0] period;
    int                    npkt[NQ];
    int                    n_pops;
    int                    exp_order[6];
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int npk[NQ];
  int seq[NQ];
  int pop_n;
  int order[16];

  function automatic logic [DS-1:0] mk_pkt(input int q, input int s);
    logic [DS-1:0] p;
    p            = '0;
    p[15:0]      = 16'(s);
    p[23:16]     = 8'(q);
    p[400 +: 16] = 16'(s * 3 + q + 7);
    p[DS-1 -: 8] = 8'hA5 ^ 8'(q);
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_pkt(input string name, input logic [DS-1:0] act, input logic [DS-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic update_inputs();
    for (int i = 0; i < NQ; i++) empty[i] = (npk[i] == 0);
    queues_to_buffer_packet = mk_pkt(int'(core_id), seq[core_id]);
  endtask

  // One clock: note any pop seen by the DUT at this edge, then apply it to the queue model.
  task automatic tick();
    logic p;
    int   id;
    p  = scheduler_to_queues_ready;
    id = int'(core_id);
    if (p === 1'b1) begin
      chk_pkt("pop_packet", out_packet, mk_pkt(id, seq[id]));
      chk("pop_nonempty", 64'(npk[id] > 0), 64'(1));
    end
    @(posedge clock);
    @(negedge clock);
    if (p === 1'b1) begin
      npk[id]--;
      seq[id]++;
      if (pop_n < 16) order[pop_n] = id;
      pop_n++;
    end
    update_inputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NQ; i++) npk[i] = 0;
    update_inputs();
    tick();
    tick();
    reset = 1'b0;
    pop_n = 0;
  endtask

  task automatic set_periods(input int p);
    for (int i = 0; i < NQ; i++) queues_period[i] = RS'(p);
  endtask

  vec_t vecs[5];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NQ; i++) begin npk[i] = 0; seq[i] = 10 * i; end
    pop_n = 0; reset = 1'b1; enable = 1'b1; out_ready = 1'b1;
    set_periods(100);
    update_inputs();
    @(negedge clock);

    // Reset then idle.
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_ready", 64'(scheduler_to_queues_ready), 64'(0));
    end
    reset = 1'b0;
    pop_n = 0;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_core_id", 64'(core_id), 64'(0));
    chk("rst_miss", 64'(deadline_miss), 64'(0));
    chk_pkt("rst_packet", out_packet, '0);
    for (int k = 0; k < 3; k++) tick();
    chk("idle_no_pop", 64'(pop_n), 64'(0));
    chk("idle_valid", 64'(out_valid), 64'(0));

    // Single-queue timing.
    set_periods(100);
    do_reset();
    npk[2] = 1;
    update_inputs();
    tick();
    chk("t2_core_id", 64'(core_id), 64'(2));
    chk("t2_valid_wait", 64'(out_valid), 64'(0));
    tick();
    chk("t2_valid_offer", 64'(out_valid), 64'(1));
    chk_pkt("t2_packet", out_packet, mk_pkt(2, seq[2]));
    chk("t2_ready", 64'(scheduler_to_queues_ready), 64'(1));
    tick();
    chk("t2_valid_done", 64'(out_valid), 64'(0));
    chk("t2_ready_done", 64'(scheduler_to_queues_ready), 64'(0));
    chk("t2_pops", 64'(pop_n), 64'(1));

    // Ordering vectors.
    vecs[0].period = {32'd100, 32'd100, 32'd100, 32'd100};
    vecs[0].npkt = '{0, 0, 1, 0}; vecs[0].n_pops = 1; vecs[0].exp_order = '{2, 0, 0, 0, 0, 0};
    vecs[1].period = {32'd20, 32'd30, 32'd10, 32'd50};
    vecs[1].npkt = '{1, 1, 1, 1}; vecs[1].n_pops = 4; vecs[1].exp_order = '{1, 3, 2, 0, 0, 0};
    vecs[2].period = {32'd40, 32'd40, 32'd40, 32'd40};
    vecs[2].npkt = '{0, 1, 0, 1}; vecs[2].n_pops = 2; vecs[2].exp_order = '{1, 3, 0, 0, 0, 0};
    vecs[3].period = {32'd7, 32'd0, 32'd5, 32'd5};
    vecs[3].npkt = '{1, 1, 1, 1}; vecs[3].n_pops = 4; vecs[3].exp_order = '{2, 0, 1, 3, 0, 0};
    vecs[4].period = {32'd100, 32'd100, 32'd20, 32'd10};
    vecs[4].npkt = '{2, 1, 0, 0}; vecs[4].n_pops = 3; vecs[4].exp_order = '{0, 0, 1, 0, 0, 0};

    out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      queues_period = vecs[v].period;
      do_reset();
      for (int i = 0; i < NQ; i++) npk[i] = vecs[v].npkt[i];
      update_inputs();
      for (int c = 0; c < 200 && pop_n < vecs[v].n_pops; c++) tick();
      chk($sformatf("vec%0d_pops", v), 64'(pop_n), 64'(vecs[v].n_pops));
      for (int k = 0; k < vecs[v].n_pops; k++)
        chk($sformatf("vec%0d_order%0d", v, k), 64'(order[k]), 64'(vecs[v].exp_order[k]));
      for (int k = 0; k < 6; k++) tick();
      chk($sformatf("vec%0d_no_extra_pop", v), 64'(pop_n), 64'(vecs[v].n_pops));
    end

    // Backpressure: ten stalled cycles in OFFER.
    set_periods(100);
    do_reset();
    out_ready = 1'b0;
    npk[1] = 1;
    update_inputs();
    tick();
    tick();
    chk("bp_valid_start", 64'(out_valid), 64'(1));
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_valid", 64'(out_valid), 64'(1));
      chk("bp_ready", 64'(scheduler_to_queues_ready), 64'(0));
      chk("bp_core_id", 64'(core_id), 64'(1));
      chk_pkt("bp_packet", out_packet, mk_pkt(1, seq[1]));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(scheduler_to_queues_ready), 64'(1));
    tick();
    chk("bp_after_ready", 64'(scheduler_to_queues_ready), 64'(0));
    chk("bp_after_valid", 64'(out_valid), 64'(0));
    chk("bp_pops", 64'(pop_n), 64'(1));

    // Enable gating, and enable dropped mid-service.
    do_reset();
    enable = 1'b0;
    npk[3] = 1;
    update_inputs();
    for (int k = 0; k < 5; k++) tick();
    chk("en_blocked_valid", 64'(out_valid), 64'(0));
    chk("en_blocked_core", 64'(core_id), 64'(0));
    enable = 1'b1;
    tick();
    chk("en_core_id", 64'(core_id), 64'(3));
    enable = 1'b0;
    tick();
    chk("en_off_valid", 64'(out_valid), 64'(1));
    tick();
    chk("en_off_pops", 64'(pop_n), 64'(1));
    enable = 1'b1;

    // Deadline miss with period 5 on queue 0, stalled downstream.
    set_periods(100);
    queues_period[0] = 32'd5;
    do_reset();
    out_ready = 1'b0;
    npk[0] = 1;
    update_inputs();
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("miss_a_k%0d", k), 64'(deadline_miss[0]), 64'(k == 6));
    end
    chk("miss_a_offer", 64'(out_valid), 64'(1));

    // Reset while offering: no pop, counter back at the period.
    reset = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rstmid_ready", 64'(scheduler_to_queues_ready), 64'(0));
    tick();
    chk("rstmid_valid", 64'(out_valid), 64'(0));
    chk("rstmid_miss", 64'(deadline_miss), 64'(0));
    reset = 1'b0;
    out_ready = 1'b0;
    chk("rstmid_no_pop", 64'(pop_n), 64'(0));
    chk("rstmid_head_kept", 64'(npk[0]), 64'(1));
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("miss_b_k%0d", k), 64'(deadline_miss[0]), 64'(k == 6));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
